// File: rtl/l1_dcache_if.sv
// CPU load/store port and L2 request port of the L1 data cache.
//
// Handshake semantics (both sides):
//   CPU side: the CPU raises cpu_read or cpu_write and holds it, together
//   with cpu_addr/cpu_data_in, until it sees the one-cycle cpu_ready pulse.
//   It must drop or change the request by the edge that ends that pulse.
//   L2 side: the cache raises l2_read or l2_write and holds l2_addr and
//   l2_data_out stable until a rising edge where l2_ready=1. That edge
//   completes the transaction and l2_data_in is captured on it. l2_ready
//   is ignored while no L2 request is outstanding.
interface l1_dcache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_data_in;
  logic                  cpu_read;
  logic                  cpu_write;
  logic [DATA_WIDTH-1:0] cpu_data_out;
  logic                  cpu_ready;
  logic [ADDR_WIDTH-1:0] l2_addr;
  logic [DATA_WIDTH-1:0] l2_data_out;
  logic [DATA_WIDTH-1:0] l2_data_in;
  logic                  l2_read;
  logic                  l2_write;
  logic                  l2_ready;

  // Cache side of the link.
  modport slave (
    input  cpu_addr, cpu_data_in, cpu_read, cpu_write, l2_data_in, l2_ready,
    output cpu_data_out, cpu_ready, l2_addr, l2_data_out, l2_read, l2_write
  );

  // Environment side: the CPU together with the L2 cache.
  modport master (
    output cpu_addr, cpu_data_in, cpu_read, cpu_write, l2_data_in, l2_ready,
    input  cpu_data_out, cpu_ready, l2_addr, l2_data_out, l2_read, l2_write
  );
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Read misses refill the whole line one word at a time over L2. Every store
// is forwarded to L2; store hits also update the local copy. Saturating
// hit/miss counters support performance monitoring. All CPU/L2 outputs are
// registered, so an L2 request is low for at least one cycle between words.
module l1_dcache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 256,
  parameter int BLOCK_SIZE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  l1_dcache_if.slave  bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [2:0]  dbg_state
);
  localparam int LINES = CACHE_SIZE / BLOCK_SIZE;
  localparam int WORDS = BLOCK_SIZE / 4;
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;
  localparam int IDX_LO = OFF_W + 2;
  localparam int TAG_LO = IDX_W + OFF_W + 2;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    REFILL_REQ  = 3'd1,
    REFILL_WAIT = 3'd2,
    WR_REQ      = 3'd3,
    RESPOND     = 3'd4
  } state_t;

  state_t state, state_n;

  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tag_arr  [LINES];
  logic [DATA_WIDTH-1:0] data_arr [LINES][WORDS];

  // Request address latched in IDLE; the CPU inputs are not re-read later.
  logic [ADDR_WIDTH-1:2] req_addr;
  logic [OFF_W-1:0]      cnt;

  logic [DATA_WIDTH-1:0] cpu_data_out_q;
  logic                  cpu_ready_q;
  logic [ADDR_WIDTH-1:0] l2_addr_q;
  logic [DATA_WIDTH-1:0] l2_data_out_q;
  logic                  l2_read_q;
  logic                  l2_write_q;

  logic [OFF_W-1:0] cpu_off, req_off;
  logic [IDX_W-1:0] cpu_idx, req_idx;
  logic [TAG_W-1:0] cpu_tag, req_tag;
  logic             cpu_hit;

  assign cpu_off = bus.cpu_addr[IDX_LO-1:2];
  assign cpu_idx = bus.cpu_addr[TAG_LO-1:IDX_LO];
  assign cpu_tag = bus.cpu_addr[ADDR_WIDTH-1:TAG_LO];
  assign req_off = req_addr[IDX_LO-1:2];
  assign req_idx = req_addr[TAG_LO-1:IDX_LO];
  assign req_tag = req_addr[ADDR_WIDTH-1:TAG_LO];
  assign cpu_hit = valid[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);

  assign bus.cpu_data_out = cpu_data_out_q;
  assign bus.cpu_ready    = cpu_ready_q;
  assign bus.l2_addr      = l2_addr_q;
  assign bus.l2_data_out  = l2_data_out_q;
  assign bus.l2_read      = l2_read_q;
  assign bus.l2_write     = l2_write_q;
  assign dbg_state        = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; stores take priority over loads in IDLE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (bus.cpu_write)     state_n = WR_REQ;
        else if (bus.cpu_read) state_n = cpu_hit ? RESPOND : REFILL_REQ;
      end
      REFILL_REQ:  state_n = REFILL_WAIT;
      REFILL_WAIT: if (bus.l2_ready) state_n = (&cnt) ? RESPOND : REFILL_REQ;
      WR_REQ:      if (bus.l2_ready) state_n = RESPOND;
      RESPOND:     state_n = IDLE;
      default:     state_n = IDLE;
    endcase
  end

  // Control, output and counter registers; reset abandons any L2 request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid          <= '0;
      req_addr       <= '0;
      cnt            <= '0;
      cpu_data_out_q <= '0;
      cpu_ready_q    <= 1'b0;
      l2_addr_q      <= '0;
      l2_data_out_q  <= '0;
      l2_read_q      <= 1'b0;
      l2_write_q     <= 1'b0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      cpu_ready_q <= (state_n == RESPOND);
      case (state)
        IDLE: begin
          if (bus.cpu_write || bus.cpu_read) begin
            req_addr <= bus.cpu_addr[ADDR_WIDTH-1:2];
            if (cpu_hit) begin
              if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
              if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
          end
          if (bus.cpu_write) begin
            l2_write_q    <= 1'b1;
            l2_addr_q     <= bus.cpu_addr & ~ADDR_WIDTH'(3);
            l2_data_out_q <= bus.cpu_data_in;
          end else if (bus.cpu_read) begin
            if (cpu_hit) cpu_data_out_q <= data_arr[cpu_idx][cpu_off];
            else         cnt <= '0;
          end
        end
        REFILL_REQ: begin
          l2_read_q <= 1'b1;
          l2_addr_q <= {req_addr[ADDR_WIDTH-1:IDX_LO], cnt, 2'b00};
        end
        REFILL_WAIT: begin
          if (bus.l2_ready) begin
            l2_read_q <= 1'b0;
            cnt       <= cnt + 1'b1;
            if (&cnt) begin
              valid[req_idx] <= 1'b1;
              // The requested word may be the one arriving on this edge.
              cpu_data_out_q <= (req_off == cnt) ? bus.l2_data_in
                                                 : data_arr[req_idx][req_off];
            end
          end
        end
        WR_REQ: if (bus.l2_ready) l2_write_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Tag and data arrays: refill words, line tag, and store-hit updates.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.cpu_write && cpu_hit)
      data_arr[cpu_idx][cpu_off] <= bus.cpu_data_in;
    if (state == REFILL_WAIT && bus.l2_ready) begin
      data_arr[req_idx][cnt] <= bus.l2_data_in;
      if (&cnt) tag_arr[req_idx] <= req_tag;
    end
  end
endmodule

// File: tb/tb_l1_dcache.sv
// Bench for l1_dcache: a CPU driver task, an L2 responder model with
// random or forced stall, and scoreboards for load data and L2 traffic.
module tb_l1_dcache;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] hit_count, miss_count;
  logic [2:0]  dbg_state;

  l1_dcache_if bus ();

  l1_dcache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .dbg_state  (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // L2 backing store; unset words get an address-derived pattern.
  logic [31:0] l2_mem [logic [31:0]];
  function automatic logic [31:0] l2_word(input logic [31:0] a);
    if (l2_mem.exists(a)) return l2_mem[a];
    return (a * 32'd2654435761) ^ 32'hC0DE_0000;
  endfunction

  logic [31:0] exp_q[$];      // expected load data
  logic [64:0] exp_l2_q[$];   // expected {write, addr, store data}
  int l2_done = 0;
  int stall_cycles = -1;
  bit cur_is_load = 1'b0;
  int exp_hits = 0;
  int exp_misses = 0;

  // L2 responder: stalls, checks hold stability, completes, logs traffic.
  always begin : l2_model
    logic [31:0] a, d;
    logic        w;
    int          n;
    bit          aborted;
    @(negedge clk);
    if (rst_n && (bus.l2_read || bus.l2_write)) begin
      a = bus.l2_addr;
      w = bus.l2_write;
      d = bus.l2_data_out;
      aborted = 1'b0;
      n = (stall_cycles >= 0) ? stall_cycles : int'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        if (!rst_n) begin
          aborted = 1'b1;
          break;
        end
        check("l2_hold", {bus.l2_read, bus.l2_write, bus.l2_addr}, {~w, w, a});
        if (w) check("l2_hold_data", bus.l2_data_out, d);
      end
      if (!aborted) begin
        check("l2_txn_expected", exp_l2_q.size() != 0, 1'b1);
        if (exp_l2_q.size() != 0)
          check("l2_txn", {w, a, (w ? d : 32'h0)}, exp_l2_q.pop_front());
        bus.l2_data_in = w ? 32'h0 : l2_word(a);
        if (w) l2_mem[a] = d;
        bus.l2_ready = 1'b1;
        l2_done++;
        @(negedge clk);
        bus.l2_ready = 1'b0;
      end
    end
  end

  // Load-data scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.cpu_ready && cur_is_load) begin
      check("load_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("load_data", bus.cpu_data_out, exp_q.pop_front());
    end
  end

  // Driver: one CPU access, with its expected L2 traffic and counters.
  task automatic cpu_access(input bit is_wr, input bit both, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit exp_hit);
    logic [31:0] a;
    int cyc;
    int d0;
    int n_l2;
    a = {addr[31:2], 2'b00};
    d0 = l2_done;
    if (is_wr) begin
      exp_l2_q.push_back({1'b1, a, wdata});
      n_l2 = 1;
    end else begin
      exp_q.push_back(l2_word(a));
      n_l2 = exp_hit ? 0 : 4;
      if (!exp_hit)
        for (int i = 0; i < 4; i++) exp_l2_q.push_back({1'b0, a[31:4], i[1:0], 2'b00, 32'h0});
    end
    if (exp_hit) exp_hits++;
    else         exp_misses++;
    @(negedge clk);
    bus.cpu_addr    = addr;
    bus.cpu_data_in = wdata;
    bus.cpu_write   = is_wr;
    bus.cpu_read    = !is_wr || both;
    cur_is_load     = !is_wr;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.cpu_ready && cyc < 300);
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    check("ready_seen", bus.cpu_ready, 1'b1);
    if (!is_wr && exp_hit) check("hit_latency", cyc, 1);
    check("l2_txn_count", l2_done - d0, n_l2);
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
    @(posedge clk);
    #1 check("ready_pulse", bus.cpu_ready, 1'b0);
  endtask

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.cpu_addr = '0;
    bus.cpu_data_in = '0;
    bus.cpu_read = 1'b0;
    bus.cpu_write = 1'b0;
    bus.l2_data_in = '0;
    bus.l2_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", bus.cpu_ready, 1'b0);
    check("rst_cpu_data", bus.cpu_data_out, 32'h0);
    check("rst_l2_req", {bus.l2_read, bus.l2_write}, 2'b00);
    check("rst_l2_addr", bus.l2_addr, 32'h0);
    check("rst_counters", {hit_count, miss_count}, 64'h0);
    check("rst_state", dbg_state, 3'd0);
    rst_n = 1'b1;

    l2_mem[32'h1000] = 32'hA0;
    l2_mem[32'h1004] = 32'hA1;
    l2_mem[32'h1008] = 32'hA2;
    l2_mem[32'h100C] = 32'hA3;

    // Cold miss with 4-word refill, then hits in the same line.
    cpu_access(1'b0, 1'b0, 32'h1004, 32'h0, 1'b0);
    cpu_access(1'b0, 1'b0, 32'h100C, 32'h0, 1'b1);
    cpu_access(1'b0, 1'b0, 32'h100E, 32'h0, 1'b1);
    // Store hit, write priority over a simultaneous read, loads see new data.
    cpu_access(1'b1, 1'b0, 32'h1008, 32'hDEAD_BEEF, 1'b1);
    cpu_access(1'b0, 1'b0, 32'h1008, 32'h0, 1'b1);
    cpu_access(1'b1, 1'b1, 32'h1004, 32'h1234_5678, 1'b1);
    cpu_access(1'b0, 1'b0, 32'h1004, 32'h0, 1'b1);
    // Store miss does not allocate; resident line survives; then load misses.
    cpu_access(1'b1, 1'b0, 32'h2000, 32'hCAFE_F00D, 1'b0);
    cpu_access(1'b0, 1'b0, 32'h1000, 32'h0, 1'b1);
    cpu_access(1'b0, 1'b0, 32'h2000, 32'h0, 1'b0);
    // Conflict misses on index 0; third load sees refreshed L2 data.
    cpu_access(1'b0, 1'b0, 32'h1000, 32'h0, 1'b0);
    cpu_access(1'b0, 1'b0, 32'h2000, 32'h0, 1'b0);
    l2_mem[32'h1000] = 32'h5555_0001;
    cpu_access(1'b0, 1'b0, 32'h1000, 32'h0, 1'b0);
    // Random-data store/load pairs on a fresh line.
    for (int k = 0; k < 4; k++) begin
      logic [31:0] wd;
      wd = $urandom;
      cpu_access(1'b1, 1'b0, 32'h40 + 32'(k * 4), wd, 1'b0);
    end
    cpu_access(1'b0, 1'b0, 32'h48, 32'h0, 1'b0);
    cpu_access(1'b0, 1'b0, 32'h44, 32'h0, 1'b1);

    // Reset in the middle of the third refill word, with a 5-cycle L2 stall.
    stall_cycles = 5;
    for (int i = 0; i < 4; i++) exp_l2_q.push_back({1'b0, 28'h0000_300, i[1:0], 2'b00, 32'h0});
    @(negedge clk);
    bus.cpu_addr = 32'h3008;
    bus.cpu_read = 1'b1;
    cur_is_load = 1'b1;
    cyc = 0;
    while (!(bus.l2_read && bus.l2_addr[3:2] == 2'd2) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_word2", {bus.l2_read, bus.l2_addr}, {1'b1, 32'h3008});
    #2;
    rst_n = 1'b0;
    bus.cpu_read = 1'b0;
    #1;
    check("abort_l2_read", bus.l2_read, 1'b0);
    check("abort_counters", {hit_count, miss_count}, 64'h0);
    check("abort_state", dbg_state, 3'd0);
    check("abort_cpu_ready", bus.cpu_ready, 1'b0);
    exp_l2_q.delete();
    exp_q.delete();
    exp_hits = 0;
    exp_misses = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    cpu_access(1'b0, 1'b0, 32'h3008, 32'h0, 1'b0);
    stall_cycles = -1;
    cpu_access(1'b0, 1'b0, 32'h3000, 32'h0, 1'b1);
    cpu_access(1'b0, 1'b0, 32'h1000, 32'h0, 1'b0);

    repeat (4) @(negedge clk);
    check("load_q_drained", exp_q.size(), 0);
    check("l2_q_drained", exp_l2_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/l1_dcache.md
Name: l1_dcache

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache between the CPU load/store port and the L2 cache.
- Serves read hits from a local array.
- Refills missed blocks word-by-word over the L2 request interface.
- Forwards every store to L2. Provides saturating hit/miss counters for performance monitoring.

Parameters:
- DATA_WIDTH, 32, word width in bits; fixed at 32 in this revision.
- ADDR_WIDTH, 32, byte address width.
- CACHE_SIZE, 256, data capacity in bytes; gives 16 lines.
- BLOCK_SIZE, 16, line size in bytes; gives 4 words per line, offset = addr[3:2], index = addr[7:4], tag = addr[31:8].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  ADDR_WIDTH  byte address; addr[1:0] ignored (word accesses only).
- cpu_data_in  in  DATA_WIDTH  store data.
- cpu_read  in  1  load request, held until cpu_ready.
- cpu_write  in  1  store request, held until cpu_ready.
- cpu_data_out  out  DATA_WIDTH  load data, valid while cpu_ready=1 for a load.
- cpu_ready  out  1  one-cycle completion pulse.
- l2_addr  out  ADDR_WIDTH  word-aligned L2 request address.
- l2_data_out  out  DATA_WIDTH  store data to L2.
- l2_data_in  in  DATA_WIDTH  refill data from L2.
- l2_read  out  1  L2 read request.
- l2_write  out  1  L2 write request.
- l2_ready  in  1  L2 completion; data/ack sampled on the edge where high.
- hit_count  out  32  saturating count of load hits plus store hits.
- miss_count  out  32  saturating count of load misses plus store misses.

Behaviour:
- Reset (async, rst_n=0):
  - All 16 valid bits cleared.
  - FSM enters IDLE.
  - All outputs 0, including both counters.
  - A refill or store in progress is abandoned; the L2 request drops immediately.
  - Tag and data arrays need not be reset.
- FSM states: IDLE, REFILL_REQ, REFILL_WAIT, WR_REQ, RESPOND.
- IDLE: samples the request on each edge. cpu_write has priority if both cpu_read and cpu_write are high.
  - Load hit (valid[index] and tag match): load the word into cpu_data_out, hit_count+1, go to RESPOND. cpu_ready is high the cycle after sampling, giving 1-cycle latency.
  - Load miss: miss_count+1, refill counter=0, go to REFILL_REQ.
  - Store hit: update the word in the array, hit_count+1, go to WR_REQ.
  - Store miss: miss_count+1, array unchanged, go to WR_REQ.
- REFILL_REQ:
  - l2_read=1, l2_addr = {tag, index, counter, 2'b00}.
  - Counter runs 0,1,2,3 in order; each word is a separate L2 transaction.
  - Go to REFILL_WAIT.
- REFILL_WAIT:
  - l2_read and l2_addr are held stable until the edge with l2_ready=1.
  - On that edge: capture l2_data_in into array word[counter], drop l2_read, counter+1.
  - If counter was 3: write the tag, set valid, put the requested word on cpu_data_out, go to RESPOND. Otherwise go back to REFILL_REQ.
  - l2_read is therefore low for at least one cycle between words.
- WR_REQ:
  - l2_write=1, l2_addr = word-aligned cpu_addr, l2_data_out = cpu_data_in; all held until l2_ready.
  - On the l2_ready edge: drop l2_write, go to RESPOND.
- RESPOND:
  - cpu_ready=1 for exactly one cycle, then return to IDLE.
  - No request is sampled in RESPOND. The CPU must drop or change its request by the edge ending the cpu_ready cycle; a request still high in IDLE is treated as a new access.
- l2_ready while no L2 request is outstanding is ignored.
- The CPU request inputs are not re-read after IDLE; address and data are latched at sampling.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- cpu_data_out holds its last value outside RESPOND.
- cpu_read and cpu_write do not affect state outside IDLE.

Test Plan:
1. Reset, then load 0x0000_1004 with L2 returning 0xA0,0xA1,0xA2,0xA3 for 0x1000..0x100C:
   - Exactly 4 l2_read transactions at 0x1000, 0x1004, 0x1008, 0x100C.
   - cpu_data_out=0xA1 with cpu_ready; miss_count=1.
2. Load 0x0000_100C after case 1:
   - No L2 activity; cpu_ready one cycle after request; data 0xA3; hit_count=1.
3. Store 0xDEAD_BEEF to 0x0000_1008 (hit), then load 0x0000_1008:
   - One l2_write at 0x1008 with that data; cpu_ready only after l2_ready.
   - Load hits and returns 0xDEAD_BEEF.
4. Store to 0x0000_2000 (miss), then load 0x0000_2000:
   - l2_write issued; no refill on the store.
   - The load misses (no allocate) and refills 0x2000..0x200C.
5. Conflict: load 0x0000_1000, then load 0x0000_2000 (same index 0), then load 0x0000_1000:
   - Three refills; third load is a miss returning refreshed L2 data.
6. Assert rst_n=0 during the third word of a refill, release, then load the same address:
   - L2 request drops immediately; counters are 0; the line is invalid and a full 4-word refill occurs.
   - Also: l2_ready stalled 5 cycles on one word keeps l2_addr/l2_read stable throughout.
